// File: rtl/otter_mem_responder.sv
// otter_mem_responder: dual-port OTTER memory with sized data access, MMIO decode and data wait states
module otter_mem_responder #(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] IO_BASE     = 32'h1100_0000,
  parameter int          DATA_WAIT   = 0,
  parameter string       INIT_FILE   = "otter_memory.mem"
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_RDEN1,
  input  logic [31:0] MEM_ADDR1,
  output logic [31:0] MEM_DOUT1,
  input  logic        MEM_RDEN2,
  input  logic        MEM_WE2,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_SIGN,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_BUSY,
  output logic        MEM_ERR,
  input  logic [31:0] IO_IN,
  output logic        IO_WR
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] DW = 3'(DATA_WAIT);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [31:0] ram [DEPTH_WORDS];
  logic req, is_io, misal, done, unused_bits;
  logic [31:0] src, sh, rd_val, wd;
  logic [3:0] be;
  logic [AW-1:0] idx1, idx2;
  assign unused_bits = ^{MEM_ADDR1[31:AW+2], MEM_ADDR1[1:0]};
  assign idx1 = MEM_ADDR1[AW+1:2];
  assign idx2 = MEM_ADDR2[AW+1:2];
  assign req = MEM_RDEN2 | MEM_WE2;
  assign is_io = MEM_ADDR2 >= IO_BASE;
  assign misal = MEM_SIZE == 2'b01 ? MEM_ADDR2[0] : MEM_SIZE[1] & |MEM_ADDR2[1:0];
  assign IO_WR = MEM_WE2 & is_io & ~misal & (state == IDLE);
  assign src = is_io ? IO_IN : ram[idx2];
  assign sh = src >> {MEM_ADDR2[1:0], 3'b000};
  assign rd_val = misal ? '0 :
                  MEM_SIZE == 2'b00 ? {{24{~MEM_SIGN & sh[7]}}, sh[7:0]} :
                  MEM_SIZE == 2'b01 ? {{16{~MEM_SIGN & sh[15]}}, sh[15:0]} : sh;
  assign be = MEM_SIZE == 2'b00 ? 4'b0001 << MEM_ADDR2[1:0] :
              MEM_SIZE == 2'b01 ? (MEM_ADDR2[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = MEM_SIZE == 2'b00 ? {4{MEM_DIN2[7:0]}} :
              MEM_SIZE == 2'b01 ? {2{MEM_DIN2[15:0]}} : MEM_DIN2;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    MEM_BUSY = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      if (req && (is_io || DW == 3'd0)) done = 1'b1;
      else if (req) begin
        MEM_BUSY = 1'b1;
        cnt_n = 3'd1;
        state_n = WAIT;
      end
    end else if (cnt < DW) begin
      MEM_BUSY = 1'b1;
      cnt_n = cnt + 3'd1;
    end else begin
      done = 1'b1;
      cnt_n = 3'd0;
      state_n = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= 3'd0;
      MEM_DOUT1 <= '0;
      MEM_DOUT2 <= '0;
      MEM_ERR <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      MEM_ERR <= done & misal;
      if (MEM_RDEN1) MEM_DOUT1 <= ram[idx1];
      if (done && MEM_RDEN2 && !MEM_WE2) MEM_DOUT2 <= rd_val;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET && done && MEM_WE2 && !is_io && !misal)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx2][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule
